// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike rate encoder.
package spike_enc_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    // Tap mask for x^16+x^14+x^13+x^11+1 (bit positions 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One Fibonacci step: shift left, parity of tapped bits enters at bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// 16-bit Fibonacci LFSR with advance enable; a zero seed falls back to
// DEFAULT_SEED so the register can never lock up at all-zeros.
module spike_lfsr
    import spike_enc_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] state_q;

    // Shift register: reload seed on reset, step once per enabled cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED_EFF;
        end else if (adv_i) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: loads NUM_CHANNELS pixels, then emits one spike vector per
// tick for WINDOW timesteps. Default coding compares a rotated LFSR slice
// against each pixel. Defining SPIKE_ENC_DETERMINISTIC_EN swaps the LFSR
// for per-channel overflow accumulators (exact floor(pix*WINDOW/2^PIX_W)).
//
//   state | meaning
//   LOAD  | accepting pixels, one per valid&ready handshake
//   RUN   | each tick emits a spike vector one cycle later
//   DONE  | single cycle carrying the last strobe and done_o
module spike_rate_encoder
    import spike_enc_pkg::*;
#(
    parameter int          NUM_CHANNELS = 8,
    parameter int          PIX_W        = 8,
    parameter int          WINDOW       = 64,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pix_valid_i,
    input  logic [PIX_W-1:0]        pix_data_i,
    output logic                    pix_ready_o,
    input  logic                    tick_i,
    input  logic                    abort_i,
    output logic [NUM_CHANNELS-1:0] spike_o,
    output logic                    spike_valid_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int STEP_W = $clog2(WINDOW);

    enc_state_t state_q, state_d;

    logic [IDX_W-1:0]        idx_q;
    logic [STEP_W-1:0]       step_q;
    logic [PIX_W-1:0]        pix_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] spike_c;
    logic [NUM_CHANNELS-1:0] spike_q;
    logic                    spike_valid_q;
    logic                    done_q;

    logic accept, last_pix, last_step, tick_run, abort_run;

    assign accept    = (state_q == LOAD) && pix_valid_i;
    assign last_pix  = (idx_q == IDX_W'(NUM_CHANNELS - 1));
    assign last_step = (step_q == STEP_W'(WINDOW - 1));
    assign abort_run = (state_q == RUN) && abort_i;
    assign tick_run  = (state_q == RUN) && tick_i && !abort_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over a coincident tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (accept && last_pix) state_d = RUN;
            RUN: begin
                if (abort_i) begin
                    state_d = LOAD;
                end else if (tick_i && last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        pix_ready_o = (state_q == LOAD);
        busy_o      = (state_q != LOAD);
    end

    // Pixel index, timestep counter and pixel storage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            step_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                pix_q[c] <= '0;
            end
        end else if (accept) begin
            pix_q[idx_q] <= pix_data_i;
            if (last_pix) begin
                idx_q  <= '0;
                step_q <= '0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end else if (abort_run) begin
            idx_q  <= '0;
            step_q <= '0;
        end else if (tick_run) begin
            step_q <= last_step ? '0 : step_q + STEP_W'(1);
        end
    end

    // Output register: strobe and vector one cycle after each RUN tick
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            spike_q       <= tick_run ? spike_c : '0;
            spike_valid_q <= tick_run;
            done_q        <= tick_run && last_step;
        end
    end

    assign spike_o       = spike_q;
    assign spike_valid_o = spike_valid_q;
    assign done_o        = done_q;

`ifdef SPIKE_ENC_DETERMINISTIC_EN

    logic [PIX_W-1:0] acc_q   [NUM_CHANNELS];
    logic [PIX_W:0]   acc_sum [NUM_CHANNELS];
    logic [15:0]      unused_seed;

    assign unused_seed = SEED;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_acc
        assign acc_sum[c] = {1'b0, acc_q[c]} + {1'b0, pix_q[c]};
        assign spike_c[c] = acc_sum[c][PIX_W];
    end

    // Accumulators restart on every entry to RUN, on abort and on reset
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_run || (accept && last_pix)) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_q[c] <= '0;
            end
        end else if (tick_run) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_q[c] <= acc_sum[c][PIX_W-1:0];
            end
        end
    end

`else

    logic [15:0] lfsr_state;

    spike_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .adv_i   (tick_run),
        .state_o (lfsr_state)
    );

    // Each channel sees the same low slice rotated by a different amount,
    // so channels are decorrelated without extra LFSRs.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_cmp
        localparam int SH = (2 * c) % PIX_W;
        logic [PIX_W-1:0] rand_c;
        if (SH == 0) begin : g_norot
            assign rand_c = lfsr_state[PIX_W-1:0];
        end else begin : g_rot
            assign rand_c = {lfsr_state[PIX_W-1-SH:0], lfsr_state[PIX_W-1:PIX_W-SH]};
        end
        assign spike_c[c] = (rand_c < pix_q[c]);
    end

    if (PIX_W < 16) begin : g_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_state[15:PIX_W];
    end

`endif

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;

    localparam int NCH = 8;
    localparam int PW  = 8;
    localparam int WIN = 64;

    typedef struct {
        logic [NCH-1:0] vec;
        logic           last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pix_valid = 1'b0;
    logic [PW-1:0]  pix_data = '0;
    logic           pix_ready;
    logic           tick = 1'b0;
    logic           abort = 1'b0;
    logic [NCH-1:0] spike;
    logic           spike_valid;
    logic           busy;
    logic           done;

    int unsigned total = 0;
    int unsigned bad   = 0;

    exp_t           sb[$];
    logic [15:0]    m_lfsr;
    logic [PW-1:0]  m_pix [NCH];
    logic [PW-1:0]  m_acc [NCH];
    logic [NCH-1:0] ref_seq [WIN];
    logic [PW-1:0]  pix_set [NCH];
    int             cnt [NCH];
    int             nstrobe;

    always #5 clk = ~clk;

    spike_rate_encoder #(
        .NUM_CHANNELS (NCH),
        .PIX_W        (PW),
        .WINDOW       (WIN),
        .SEED         (16'hACE1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_valid_i   (pix_valid),
        .pix_data_i    (pix_data),
        .pix_ready_o   (pix_ready),
        .tick_i        (tick),
        .abort_i       (abort),
        .spike_o       (spike),
        .spike_valid_o (spike_valid),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        for (int c = 0; c < NCH; c++) m_acc[c] = '0;
    endtask

    // Independent reference for one timestep
    task automatic model_tick(output logic [NCH-1:0] v);
        logic [15:0] dbl;
        logic [PW:0] sum;
        logic        fb;
        v = '0;
`ifdef SPIKE_ENC_DETERMINISTIC_EN
        for (int c = 0; c < NCH; c++) begin
            sum = {1'b0, m_acc[c]} + {1'b0, m_pix[c]};
            v[c] = (sum >= 9'd256);
            m_acc[c] = sum[PW-1:0];
        end
`else
        for (int c = 0; c < NCH; c++) begin
            dbl = {m_lfsr[7:0], m_lfsr[7:0]} << ((2 * c) % 8);
            v[c] = (dbl[15:8] < m_pix[c]);
        end
        fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = {m_lfsr[14:0], fb};
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        tick = 1'b0;
        abort = 1'b0;
        repeat (3) clk1();
        rst = 1'b0;
        model_reset();
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            // ticks and aborts in LOAD must be ignored
            tick  = (i % 2 == 0);
            abort = (i == 3);
            clk1();
            total++;
            if (pix_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready: cycle %0d got %b want 1", i, pix_ready);
            end
            total++;
            if ({spike_valid, busy, done} !== 3'b000 || spike !== '0) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d got v=%b b=%b d=%b s=%h want 0", i, spike_valid, busy, done, spike);
            end
        end
        tick  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic load_pixels();
        int acc_cnt;
        int cyc;
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < NCH && cyc < 40) begin
            pix_valid = (cyc % 2 == 0);
            pix_data  = pix_valid ? pix_set[acc_cnt] : PW'($urandom);
            total++;
            if (pix_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL load_ready: cycle %0d got ready=%b busy=%b want 1/0", cyc, pix_ready, busy);
            end
            clk1();
            if (pix_valid) acc_cnt++;
            cyc++;
        end
        pix_valid = 1'b0;
        total++;
        if (acc_cnt != NCH) begin
            bad++;
            $display("FAIL load_count: got %0d accepts want %0d", acc_cnt, NCH);
        end
        total++;
        if (busy !== 1'b1 || pix_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_enter_run: got busy=%b ready=%b want 1/0", busy, pix_ready);
        end
        for (int c = 0; c < NCH; c++) begin
            m_pix[c] = pix_set[c];
            m_acc[c] = '0;
        end
    endtask

    // Runs up to n ticks; stop_at>0 raises abort (use_rst=0) or reset
    // (use_rst=1) together with that tick.
    task automatic run_window(input int n, input bit gaps, input int stop_at,
                              input bit use_rst, input bit use_ref, input bit capture);
        logic [NCH-1:0] v;
        exp_t e;
        bit stopped;
        stopped = 1'b0;
        nstrobe = 0;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        for (int k = 1; k <= n && !stopped; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    clk1();
                    total++;
                    if (spike_valid !== 1'b0 || spike !== '0 || done !== 1'b0) begin
                        bad++;
                        $display("FAIL gap_idle: got v=%b s=%h d=%b want 0", spike_valid, spike, done);
                    end
                end
            end
            tick = 1'b1;
            if (k == stop_at) begin
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
                clk1();
                tick = 1'b0;
                abort = 1'b0;
                rst = 1'b0;
                stopped = 1'b1;
                total++;
                if (spike_valid !== 1'b0 || done !== 1'b0 || spike !== '0) begin
                    bad++;
                    $display("FAIL stop_no_strobe: tick %0d got v=%b d=%b s=%h want 0", k, spike_valid, done, spike);
                end
                total++;
                if (pix_ready !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL stop_to_load: tick %0d got ready=%b busy=%b want 1/0", k, pix_ready, busy);
                end
                if (use_rst) model_reset();
            end else begin
                model_tick(v);
                if (use_ref) v = ref_seq[k-1];
                if (capture) ref_seq[k-1] = v;
                e.vec  = v;
                e.last = (k == WIN);
                sb.push_back(e);
                clk1();
                tick = 1'b0;
                total++;
                if (spike_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL strobe_missing: tick %0d got %b want 1", k, spike_valid);
                end else if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe_extra: tick %0d got strobe want none queued", k);
                end else begin
                    e = sb.pop_front();
                    nstrobe++;
                    for (int c = 0; c < NCH; c++) cnt[c] += int'(spike[c]);
                    total++;
                    if (spike !== e.vec) begin
                        bad++;
                        $display("FAIL spike_vec: tick %0d got %h want %h", k, spike, e.vec);
                    end
                    total++;
                    if (done !== e.last || busy !== 1'b1) begin
                        bad++;
                        $display("FAIL done_busy: tick %0d got done=%b busy=%b want %b/1", k, done, busy, e.last);
                    end
                end
            end
        end
        sb.delete();
        if (!stopped && n == WIN) begin
            total++;
            if (nstrobe != WIN) begin
                bad++;
                $display("FAIL strobe_count: got %0d want %0d", nstrobe, WIN);
            end
            clk1();
            total++;
            if (pix_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || spike_valid !== 1'b0) begin
                bad++;
                $display("FAIL done_to_load: got ready=%b busy=%b done=%b v=%b want 1/0/0/0", pix_ready, busy, done, spike_valid);
            end
        end
    endtask

    task automatic test_first_run();
        int exp_det [NCH];
        load_pixels();
`ifdef SPIKE_ENC_DETERMINISTIC_EN
        exp_det = '{0, 0, 1, 16, 32, 48, 63, 63};
        run_window(WIN, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < NCH; c++) begin
            total++;
            if (cnt[c] != exp_det[c]) begin
                bad++;
                $display("FAIL det_count: ch %0d got %0d want %0d", c, cnt[c], exp_det[c]);
            end
        end
`else
        exp_det = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_window(WIN, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        total++;
        if (cnt[0] != exp_det[0]) begin
            bad++;
            $display("FAIL lfsr_ch0_count: got %0d want 0", cnt[0]);
        end
        total++;
        if (cnt[7] < 60) begin
            bad++;
            $display("FAIL lfsr_ch7_count: got %0d want >=60", cnt[7]);
        end
`endif
    endtask

    task automatic test_abort();
        load_pixels();
        run_window(10, 1'b1, 10, 1'b0, 1'b0, 1'b0);
        total++;
        if (nstrobe != 9) begin
            bad++;
            $display("FAIL abort_strobes: got %0d want 9", nstrobe);
        end
        load_pixels();
        run_window(WIN, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_pixels();
        run_window(30, 1'b0, 30, 1'b1, 1'b0, 1'b0);
        total++;
        if (nstrobe != 29) begin
            bad++;
            $display("FAIL rst_mid_strobes: got %0d want 29", nstrobe);
        end
        load_pixels();
        run_window(WIN, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        pix_set = '{8'd0, 8'd1, 8'd4, 8'd64, 8'd128, 8'd192, 8'd254, 8'd255};
        test_reset();
        test_first_run();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
